// File: rtl/jtframe_romarb_if.sv
// Bus bundle between the romrq slots, the ROM arbiter and the SDRAM read port.
//   slot_req/slot_addr  : per-slot level request and 22-bit word address
//   slot_we             : one-hot grant / write-enable back to the slots
//   dout/dout_ok        : returned word and its strobe, broadcast to all slots
//   sdram_req/addr      : read request towards the SDRAM controller
//   sdram_ack/rdy/din   : controller accept, data valid and read data
//   timeout             : one-cycle pulse when a read is abandoned
// master: the arbiter's view.  slave: the surrounding slots + controller.
interface jtframe_romarb_if #(
   parameter int SLOTS = 4
);
   logic [SLOTS-1:0]    slot_req;
   logic [22*SLOTS-1:0] slot_addr;
   logic [SLOTS-1:0]    slot_we;
   logic [31:0]         dout;
   logic                dout_ok;
   logic                sdram_req;
   logic [21:0]         sdram_addr;
   logic                sdram_ack;
   logic                sdram_rdy;
   logic [31:0]         sdram_din;
   logic                timeout;

   modport master (
      input  slot_req, slot_addr, sdram_ack, sdram_rdy, sdram_din,
      output slot_we, dout, dout_ok, sdram_req, sdram_addr, timeout
   );

   modport slave (
      output slot_req, slot_addr, sdram_ack, sdram_rdy, sdram_din,
      input  slot_we, dout, dout_ok, sdram_req, sdram_addr, timeout
   );
endinterface

// File: rtl/jtframe_romarb.sv
// Round-robin arbiter between SLOTS romrq request slots and one SDRAM read
// port. One read in flight at a time; the winner's address is forwarded, the
// returned word is broadcast and only the winner's slot_we is raised.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : jtframe_romarb_if.master (slot side + SDRAM side, all outputs registered)
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no transaction; pick next requester after last winner
// ST_WAIT_ACK  | sdram_req high, waiting for controller to accept
// ST_WAIT_DATA | accepted, waiting for sdram_rdy; watchdog running
// ST_DONE      | dout_ok and slot_we high this single cycle
module jtframe_romarb #(
   parameter int SLOTS = 4,
   parameter int TOW   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   jtframe_romarb_if.master bus
);
   localparam int LW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   // Watchdog holds cycles elapsed since the ack cycle; firing when it holds
   // 2^TOW-2 puts the timeout pulse 2^TOW-1 cycles after the ack.
   localparam logic [TOW-1:0] WD_LAST = {{(TOW-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_ACK,
      ST_WAIT_DATA,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [LW-1:0]    last_q, last_d;
   logic [TOW-1:0]   wd_q, wd_d;
   logic [SLOTS-1:0] slot_we_q, slot_we_d;
   logic [31:0]      dout_q, dout_d;
   logic             dout_ok_q, dout_ok_d;
   logic             sdram_req_q, sdram_req_d;
   logic [21:0]      sdram_addr_q, sdram_addr_d;
   logic             timeout_q, timeout_d;

   logic [21:0]      addr_arr [SLOTS];
   logic [LW-1:0]    win;
   logic             any_req;

   for (genvar i = 0; i < SLOTS; i++) begin : g_addr
      assign addr_arr[i] = bus.slot_addr[22*i +: 22];
   end

   // Scan last+SLOTS down to last+1 so the nearest requester after last wins.
   always_comb begin
      logic [LW:0]   sum;
      logic [LW-1:0] cand;
      win     = last_q;
      any_req = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int k = SLOTS; k >= 1; k--) begin
         sum = {1'b0, last_q} + (LW+1)'(k);
         if (sum >= (LW+1)'(SLOTS)) sum = sum - (LW+1)'(SLOTS);
         cand = sum[LW-1:0];
         if (bus.slot_req[cand]) begin
            win     = cand;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      wd_d         = wd_q;
      slot_we_d    = slot_we_q;
      dout_d       = dout_q;
      dout_ok_d    = 1'b0;
      sdram_req_d  = sdram_req_q;
      sdram_addr_d = sdram_addr_q;
      timeout_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               last_d       = win;
               sdram_addr_d = addr_arr[win];
               sdram_req_d  = 1'b1;
               slot_we_d    = SLOTS'(1) << win;
               state_d      = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (bus.sdram_ack) begin
               sdram_req_d = 1'b0;
               wd_d        = TOW'(1);
               state_d     = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (bus.sdram_rdy) begin
               dout_d    = bus.sdram_din;
               dout_ok_d = 1'b1;
               state_d   = ST_DONE;
            end else if (wd_q == WD_LAST) begin
               slot_we_d = '0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               wd_d = wd_q + TOW'(1);
            end
         end
         ST_DONE: begin
            slot_we_d = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_q       <= LW'(SLOTS-1);
         wd_q         <= '0;
         slot_we_q    <= '0;
         dout_q       <= '0;
         dout_ok_q    <= 1'b0;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         wd_q         <= wd_d;
         slot_we_q    <= slot_we_d;
         dout_q       <= dout_d;
         dout_ok_q    <= dout_ok_d;
         sdram_req_q  <= sdram_req_d;
         sdram_addr_q <= sdram_addr_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.slot_we    = slot_we_q;
   assign bus.dout       = dout_q;
   assign bus.dout_ok    = dout_ok_q;
   assign bus.sdram_req  = sdram_req_q;
   assign bus.sdram_addr = sdram_addr_q;
   assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_jtframe_romarb.sv
module tb_jtframe_romarb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_mis = 0;

   jtframe_romarb_if #(.SLOTS(4)) bus ();

   jtframe_romarb #(.SLOTS(4), .TOW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [87:0] addr;
      logic        ack;
      logic        rdy;
      logic [31:0] din;
      logic [3:0]  e_we;
      logic        e_req;
      logic [21:0] e_addr;
      logic        e_ok;
      logic [31:0] e_dout;
   } vec_t;

   vec_t vq[$];

   function automatic logic [87:0] pk(input logic [21:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic add(input logic [3:0] req, input logic [87:0] addr,
                      input logic ack, input logic rdy, input logic [31:0] din,
                      input logic [3:0] e_we, input logic e_req,
                      input logic [21:0] e_addr, input logic e_ok,
                      input logic [31:0] e_dout);
      vec_t v;
      v.req = req; v.addr = addr; v.ack = ack; v.rdy = rdy; v.din = din;
      v.e_we = e_we; v.e_req = e_req; v.e_addr = e_addr; v.e_ok = e_ok;
      v.e_dout = e_dout;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [3:0] we, input logic req,
                          input logic [21:0] addr, input logic ok,
                          input logic [31:0] dout, input logic to);
      chk({nm, " slot_we"},    32'(bus.slot_we),    32'(we));
      chk({nm, " sdram_req"},  32'(bus.sdram_req),  32'(req));
      chk({nm, " sdram_addr"}, 32'(bus.sdram_addr), 32'(addr));
      chk({nm, " dout_ok"},    32'(bus.dout_ok),    32'(ok));
      chk({nm, " dout"},       bus.dout,            dout);
      chk({nm, " timeout"},    32'(bus.timeout),    32'(to));
   endtask

   task automatic idle_inputs();
      bus.slot_req  = '0;
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b0;
      bus.sdram_din = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      chk_all("reset", 4'b0, 1'b0, 22'h0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      logic [87:0] a1, a2, a3;
      int exp_slot;

      bus.slot_addr = '0;
      idle_inputs();

      a1 = pk(22'h3ABCDE, 22'h0A0A0A, 22'h012345, 22'h300003);
      a2 = pk(22'h000111, 22'h0A0A0A, 22'h012345, 22'h300003);
      //   req      addr ack rdy din            we      rq addr       ok dout
      add(4'b0100, a1, 0, 0, 32'h0,        4'b0100, 1, 22'h012345, 0, 32'h0);
      add(4'b0000, a1, 1, 0, 32'h0,        4'b0100, 0, 22'h012345, 0, 32'h0);
      add(4'b0000, a1, 0, 0, 32'h0,        4'b0100, 0, 22'h012345, 0, 32'h0);
      add(4'b0000, a1, 0, 1, 32'hDEADBEEF, 4'b0100, 0, 22'h012345, 1, 32'hDEADBEEF);
      add(4'b0000, a1, 0, 0, 32'h0,        4'b0000, 0, 22'h012345, 0, 32'hDEADBEEF);
      add(4'b0000, a1, 0, 1, 32'h11111111, 4'b0000, 0, 22'h012345, 0, 32'hDEADBEEF);
      add(4'b0001, a1, 0, 0, 32'h0,        4'b0001, 1, 22'h3ABCDE, 0, 32'hDEADBEEF);
      add(4'b0000, a2, 0, 1, 32'h22222222, 4'b0001, 1, 22'h3ABCDE, 0, 32'hDEADBEEF);
      add(4'b0000, a2, 1, 0, 32'h0,        4'b0001, 0, 22'h3ABCDE, 0, 32'hDEADBEEF);
      add(4'b0000, a2, 1, 0, 32'h0,        4'b0001, 0, 22'h3ABCDE, 0, 32'hDEADBEEF);
      add(4'b0000, a2, 0, 1, 32'hCAFEF00D, 4'b0001, 0, 22'h3ABCDE, 1, 32'hCAFEF00D);
      add(4'b0000, a2, 0, 0, 32'h0,        4'b0000, 0, 22'h3ABCDE, 0, 32'hCAFEF00D);
      add(4'b0000, a2, 1, 0, 32'h0,        4'b0000, 0, 22'h3ABCDE, 0, 32'hCAFEF00D);
      add(4'b1010, a1, 0, 0, 32'h0,        4'b0010, 1, 22'h0A0A0A, 0, 32'hCAFEF00D);
      add(4'b1000, a1, 1, 0, 32'h0,        4'b0010, 0, 22'h0A0A0A, 0, 32'hCAFEF00D);
      add(4'b1000, a1, 0, 1, 32'h12345678, 4'b0010, 0, 22'h0A0A0A, 1, 32'h12345678);
      add(4'b1000, a1, 0, 0, 32'h0,        4'b0000, 0, 22'h0A0A0A, 0, 32'h12345678);
      add(4'b1000, a1, 0, 0, 32'h0,        4'b1000, 1, 22'h300003, 0, 32'h12345678);
      add(4'b0000, a1, 1, 0, 32'h0,        4'b1000, 0, 22'h300003, 0, 32'h12345678);
      add(4'b0000, a1, 0, 1, 32'hFFFFFFFF, 4'b1000, 0, 22'h300003, 1, 32'hFFFFFFFF);
      add(4'b0000, a1, 0, 0, 32'h0,        4'b0000, 0, 22'h300003, 0, 32'hFFFFFFFF);

      do_reset();
      for (int i = 0; i < vq.size(); i++) begin
         bus.slot_req  = vq[i].req;
         bus.slot_addr = vq[i].addr;
         bus.sdram_ack = vq[i].ack;
         bus.sdram_rdy = vq[i].rdy;
         bus.sdram_din = vq[i].din;
         step();
         chk_all($sformatf("v%0d", i), vq[i].e_we, vq[i].e_req, vq[i].e_addr,
                 vq[i].e_ok, vq[i].e_dout, 1'b0);
      end

      // Round-robin with all slots requesting continuously.
      do_reset();
      a3 = pk(22'h100000, 22'h100111, 22'h100222, 22'h100333);
      bus.slot_addr = a3;
      bus.slot_req  = 4'b1111;
      exp_slot = 0;
      step();
      for (int t = 0; t < 5; t++) begin
         chk($sformatf("rr%0d slot_we", t), 32'(bus.slot_we), 32'(4'b0001 << exp_slot));
         chk($sformatf("rr%0d sdram_req", t), 32'(bus.sdram_req), 32'd1);
         chk($sformatf("rr%0d sdram_addr", t), 32'(bus.sdram_addr),
             32'(22'h100000 + 22'(exp_slot * 'h111)));
         bus.sdram_ack = 1'b1;
         step();
         bus.sdram_ack = 1'b0;
         bus.sdram_rdy = 1'b1;
         bus.sdram_din = 32'hA0 + 32'(t);
         step();
         bus.sdram_rdy = 1'b0;
         chk($sformatf("rr%0d dout_ok", t), 32'(bus.dout_ok), 32'd1);
         chk($sformatf("rr%0d dout", t), bus.dout, 32'hA0 + 32'(t));
         step();
         chk($sformatf("rr%0d we_off", t), 32'(bus.slot_we), 32'd0);
         step();
         exp_slot = (exp_slot + 1) % 4;
      end

      // Delayed ack: outputs must hold for 10 cycles.
      do_reset();
      bus.slot_addr = pk(22'h0, 22'h2AAAAA, 22'h0, 22'h155555);
      bus.slot_req  = 4'b0010;
      step();
      bus.slot_req  = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("dack%0d sdram_req", c), 32'(bus.sdram_req), 32'd1);
         chk($sformatf("dack%0d sdram_addr", c), 32'(bus.sdram_addr), 32'h2AAAAA);
         chk($sformatf("dack%0d slot_we", c), 32'(bus.slot_we), 32'b0010);
      end
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      chk("dack req_low", 32'(bus.sdram_req), 32'd0);
      bus.sdram_rdy = 1'b1;
      bus.sdram_din = 32'h0BADF00D;
      step();
      bus.sdram_rdy = 1'b0;
      chk("dack dout_ok", 32'(bus.dout_ok), 32'd1);
      step();

      // Watchdog: slot 3 granted, acked, never answered; slot 0 waits behind it.
      bus.slot_req = 4'b1000;
      step();
      chk("wd grant", 32'(bus.slot_we), 32'b1000);
      bus.slot_req  = 4'b0001;
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         chk($sformatf("wd%0d timeout", k), 32'(bus.timeout), 32'd0);
         chk($sformatf("wd%0d dout_ok", k), 32'(bus.dout_ok), 32'd0);
         chk($sformatf("wd%0d slot_we", k), 32'(bus.slot_we), 32'b1000);
         step();
      end
      chk_all("wd fire", 4'b0000, 1'b0, 22'h155555, 1'b0, 32'h0BADF00D, 1'b1);
      step();
      chk_all("wd next", 4'b0001, 1'b1, 22'h0, 1'b0, 32'h0BADF00D, 1'b0);
      bus.slot_req  = 4'b0000;
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      bus.sdram_rdy = 1'b1;
      bus.sdram_din = 32'h55AA55AA;
      step();
      bus.sdram_rdy = 1'b0;
      chk("wd next dout", bus.dout, 32'h55AA55AA);
      step();

      // Async reset in WAIT_DATA; slot 0 must then beat slot 3.
      bus.slot_addr = pk(22'h00F00F, 22'h0, 22'h222222, 22'h333333);
      bus.slot_req  = 4'b0100;
      step();
      bus.slot_req  = 4'b0000;
      bus.sdram_ack = 1'b1;
      step();
      bus.sdram_ack = 1'b0;
      step();
      chk("ar pre slot_we", 32'(bus.slot_we), 32'b0100);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("ar mid", 4'b0, 1'b0, 22'h0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b1;
      bus.slot_req = 4'b1001;
      step();
      chk_all("ar after", 4'b0001, 1'b1, 22'h00F00F, 1'b0, 32'h0, 1'b0);
      bus.slot_req = 4'b0000;
      step();
      chk("ar no ok", 32'(bus.dout_ok), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
